// File: rtl/child_rr_dispatcher.sv
// Round-robin dispatcher: one holding register feeding N_CHILD lanes in strict rotation,
// with a wrapping count of completed output handshakes.
module child_rr_dispatcher #(
  parameter  int N_CHILD = 5,
  parameter  int DATA_W  = 8,
  parameter  int CNT_W   = 16,
  localparam int LANE_W  = (N_CHILD > 1) ? $clog2(N_CHILD) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic [N_CHILD-1:0]  out_valid,
  input  logic [N_CHILD-1:0]  out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [LANE_W-1:0]   lane_sel,
  output logic [CNT_W-1:0]    total_cnt,
  output logic                idle
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CHILD-1:0]  valid_q, valid_d;
  logic                fire_s;
  logic [LANE_W-1:0]   lane_next_s;

  // Only the selected lane's ready bit is looked at, so the other bits cannot leak into any output.
  always_comb begin
    fire_s = (state_q == ST_FULL) && out_ready[lane_q];
    if (lane_q == LANE_W'(N_CHILD - 1)) begin
      lane_next_s = {LANE_W{1'b0}};
    end else begin
      lane_next_s = lane_q + LANE_W'(1);
    end
  end

  // Next-state logic for the holding register, rotation pointer and dispatch counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          state_d = ST_FULL;
          data_d  = in_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire_s) begin
          lane_d = lane_next_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (in_valid) begin
            state_d = ST_FULL;
            data_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (state_d == ST_FULL) begin
      valid_d = N_CHILD'(1) << lane_d;
    end else begin
      valid_d = {N_CHILD{1'b0}};
    end
  end

  // State registers; reset discards any held word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= {DATA_W{1'b0}};
      lane_q  <= {LANE_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= {N_CHILD{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // A refill is accepted on the same cycle the held word leaves.
  assign in_ready  = (state_q == ST_EMPTY) || fire_s;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign lane_sel  = lane_q;
  assign total_cnt = cnt_q;
  assign idle      = (state_q == ST_EMPTY) && !in_valid;

endmodule
